// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the MIPS32 hazard/forwarding unit.
// Build option HAZARD_MDU_EN is consumed by fwd_hazard_unit.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_RSVD = 2'b11;

  localparam int REG_ZERO  = 0;
  localparam int MDU_CNT_W = 6;

  // Execute producer wins over memory producer.
  function automatic logic [1:0] fwd_sel(
    input logic ex_hit,
    input logic mem_hit
  );
    if (ex_hit)
      return FWD_MEM;
    else if (mem_hit)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// One source specifier compared against one producer.
// Register zero never matches.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] src,
  input  logic [W-1:0] dst,
  input  logic         en,
  output logic         match
);

  assign match = en
               && (src != W'(REG_ZERO))
               && (src == dst);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects, stall/flush and optional MDU busy tracking.
// Define HAZARD_MDU_EN to build the MDU counter and MDU stall term.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic                  reg_write_e,
  input  logic                  reg_write_m,
  input  logic                  mem_to_reg_e,
  input  logic                  mem_to_reg_m,
  input  logic                  branch_d,
  input  logic                  mdu_start_e,
  input  logic                  mdu_use_d,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  forward_a_d,
  output logic                  forward_b_d,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_e,
  output logic                  mdu_busy,
  output logic                  mdu_done
);

  localparam logic [MDU_CNT_W-1:0] MDU_LOAD =
    MDU_CNT_W'(MDU_CYCLES);

  // Producers: 0 ex write, 1 mem write, 2 ex load, 3 mem load.
  logic [3:0][REG_ADDR_W-1:0] prod_reg;
  logic [3:0]                 prod_en;
  logic [3:0]                 hit_rs;
  logic [3:0]                 hit_rt;

  assign prod_reg = {write_reg_m, write_reg_e,
                     write_reg_m, write_reg_e};
  assign prod_en  = {mem_to_reg_m, mem_to_reg_e,
                     reg_write_m, reg_write_e};

  for (genvar p = 0; p < 4; p++) begin : g_prod
    fwd_match #(.W(REG_ADDR_W)) u_rs (
      .src   (rs_d),
      .dst   (prod_reg[p]),
      .en    (prod_en[p]),
      .match (hit_rs[p])
    );
    fwd_match #(.W(REG_ADDR_W)) u_rt (
      .src   (rt_d),
      .dst   (prod_reg[p]),
      .en    (prod_en[p]),
      .match (hit_rt[p])
    );
  end

  logic load_use;
  logic branch_stall;
  logic mdu_stall;
  logic stall;

  assign load_use     = hit_rs[2] | hit_rt[2];
  assign branch_stall = branch_d
                      & (hit_rs[0] | hit_rt[0]
                       | hit_rs[3] | hit_rt[3]);
  assign stall        = load_use | branch_stall | mdu_stall;

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  assign forward_a_d = hit_rs[1];
  assign forward_b_d = hit_rt[1];

  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign sel_a = fwd_sel(hit_rs[0], hit_rs[1]);
  assign sel_b = fwd_sel(hit_rt[0], hit_rt[1]);

  // A bubble enters execute on stall and needs no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      forward_a_e <= FWD_RF;
      forward_b_e <= FWD_RF;
    end else if (stall) begin
      forward_a_e <= FWD_RF;
      forward_b_e <= FWD_RF;
    end else begin
      forward_a_e <= sel_a;
      forward_b_e <= sel_b;
    end
  end

`ifdef HAZARD_MDU_EN
  logic [MDU_CNT_W-1:0] count;
  logic                 done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (count == MDU_CNT_W'(1)) && !mdu_start_e;
      if (mdu_start_e)
        count <= MDU_LOAD;
      else if (count != '0)
        count <= count - MDU_CNT_W'(1);
    end
  end

  assign mdu_busy  = (count != '0);
  assign mdu_done  = done_q;
  assign mdu_stall = mdu_busy & mdu_use_d;
`else
  logic unused_mdu;

  assign unused_mdu = ^{mdu_start_e, mdu_use_d, MDU_LOAD};
  assign mdu_busy   = 1'b0;
  assign mdu_done   = 1'b0;
  assign mdu_stall  = 1'b0;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Pipeline hazard controller for the 5-stage MIPS32 core. It sits directly upstream of the execute-stage 4-input operand muxes and drives their 2-bit selects. It also generates decode-stage branch-compare bypass selects, fetch/decode stall, and execute flush. A multi-cycle multiply/divide (MDU) busy counter is included as a build option. Execute-stage forward selects are computed during decode and registered, so they are stable from the first edge of the execute cycle.

## Interface
Parameters:
- REG_ADDR_W, 5, register specifier width
- MDU_CYCLES, 32, MDU latency in cycles; legal range 2..63

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_d, rt_d  in  REG_ADDR_W  source specifiers of the instruction in decode
- write_reg_e, write_reg_m  in  REG_ADDR_W  destination specifiers in execute and memory
- reg_write_e, reg_write_m  in  1  destination write enables
- mem_to_reg_e, mem_to_reg_m  in  1  instruction in that stage is a load
- branch_d  in  1  decode instruction is a branch that compares registers
- mdu_start_e  in  1  MDU operation issued in execute this cycle
- mdu_use_d  in  1  decode instruction reads HI/LO or issues an MDU op
- forward_a_e, forward_b_e  out  2  registered operand mux selects
- forward_a_d, forward_b_d  out  1  branch-compare bypass from memory-stage ALU result
- stall_f, stall_d  out  1  hold PC and the IF/ID register
- flush_e  out  1  clear ID/EX into a bubble
- mdu_busy  out  1  MDU in progress
- mdu_done  out  1  one-cycle pulse when the MDU completes

## Operation
- Select encoding: 00 = register file, 01 = writeback result, 10 = memory-stage ALU result, 11 = reserved.
- 11 is never produced.
- Forward select computation in decode, per source s (rs_d or rt_d):
  - Result is 10 if s≠0, reg_write_e is 1 and write_reg_e==s.
  - Otherwise 01 if s≠0, reg_write_m is 1 and write_reg_m==s.
  - Otherwise 00.
  - The execute producer takes priority over the memory producer.
- The forward select registers load the decode computation every cycle. They load 00 when stall_d=1, because the bubble entering execute needs no bypass.
- forward_a_d = (rs_d≠0 && reg_write_m && write_reg_m==rs_d). forward_b_d is the same using rt_d. Both are combinational.
- Load-use stall: mem_to_reg_e && write_reg_e≠0 && (write_reg_e==rs_d || write_reg_e==rt_d).
- Branch stall applies when branch_d is 1 and either condition holds:
  - reg_write_e and write_reg_e matches a nonzero rs_d or rt_d.
  - mem_to_reg_m and write_reg_m matches a nonzero rs_d or rt_d.
- MDU stall: mdu_busy && mdu_use_d.
- stall_f = stall_d = flush_e = OR of the three stall terms. All are combinational.
- MDU counter:
  - Width is 6 bits.
  - mdu_start_e=1 loads MDU_CYCLES; otherwise the counter decrements while nonzero.
  - mdu_busy = (count≠0), driven from the register.
  - mdu_start_e while busy reloads the counter. This is a protocol violation, but its behaviour is defined.
- mdu_done is registered and pulses for exactly one cycle after the count goes 1→0.

## Timing
- Reset (asynchronous assert, synchronous release): forward_*_e=00, count=0, mdu_busy=0, mdu_done=0.
- Combinational outputs follow their inputs during reset.
- Forward select latency: decode inputs at cycle t appear on forward_*_e in cycle t+1, when the instruction occupies execute.
- MDU: start at edge t gives mdu_busy=1 for cycles t+1..t+MDU_CYCLES, and mdu_done=1 in cycle t+MDU_CYCLES+1.
- Stall and MDU start asserted in the same cycle: the counter loads, and the stall uses the pre-load busy value.
- Reset asserted mid-MDU: the counter clears immediately and no mdu_done pulse is generated.

## Configuration
- HAZARD_MDU_EN defined: the MDU counter, MDU stall term, mdu_busy and mdu_done are present.
- HAZARD_MDU_EN undefined:
  - The counter is removed.
  - mdu_busy and mdu_done are tied 0.
  - The MDU stall term is 0.
  - mdu_start_e and mdu_use_d are ignored.
  - The port list is unchanged.

## Structure
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, FWD_RSVD=2'b11
  - REG_ZERO
  - the MDU counter width constant
- Sub-module fwd_match: one source specifier against one producer (specifier, write enable), producing match = nonzero && equal && enable.
- fwd_match is instantiated once per source/producer pair.

## Test plan
- rs_d=5, reg_write_e=1, write_reg_e=5, and write_reg_m=5 also writing → forward_a_e=10 next cycle (execute priority); stall_f=0.
- rt_d=7, write_reg_m=7, reg_write_m=1, no execute match → forward_b_e=01 next cycle; forward_b_d=1.
- Load in execute with write_reg_e=3, rs_d=3 → stall_f=stall_d=flush_e=1 for one cycle; forward_*_e=00 next cycle.
- rs_d=0, write_reg_e=0, reg_write_e=1 → no forward, no stall.
- branch_d=1, rt_d=9, mem_to_reg_m=1, write_reg_m=9 → stall asserted; the same case with mem_to_reg_m=0 → forward_b_d=1, no stall.
- HAZARD_MDU_EN, MDU_CYCLES=4:
  - mdu_start_e at edge 0 → mdu_busy for cycles 1–4 and mdu_done in cycle 5.
  - mdu_use_d in cycle 2 → stall in cycle 2.
  - rst_n pulsed low in cycle 3 → busy=0 immediately and no done pulse.
